// File: rtl/pc_pkg.sv
// Shared constants, state encoding and LFSR helpers
// for the binary symmetric channel block.
package pc_pkg;

  localparam int N      = 256;
  localparam int LANE_W = 32;

  // x^32+x^22+x^2+x+1, right-shifting Galois taps
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] ZERO_SEED = 32'h0000_0001;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return s[0] ? ((s >> 1) ^ LFSR_POLY)
                : (s >> 1);
  endfunction

  // Lane 1 would map to zero, so it falls back
  // to the bare constant.
  function automatic logic [31:0] seed_fix(
    input logic [31:0] s,
    input int unsigned idx
  );
    logic [31:0] r;
    r = ZERO_SEED ^ 32'(idx);
    if (r == '0) r = ZERO_SEED;
    return (s == '0) ? r : s;
  endfunction

endpackage

// File: rtl/bsc_channel_256_if.sv
// Row stream bundle: encoder side in, decoder side out.
// slave = channel block, master = driver/consumer.
interface bsc_channel_256_if #(
  parameter int N = pc_pkg::N
);

  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0]           in_row;
  logic [15:0]            cross_prob;
  logic                   out_valid;
  logic                   out_ready;
  logic [N-1:0]           out_row;
  logic [N-1:0]           out_err;
  logic [$clog2(N)-1:0]   out_idx;
  logic                   out_last;
  logic [$clog2(N+1)-1:0] out_nerr;

  modport slave (
    input  in_valid, in_row, cross_prob, out_ready,
    output in_ready, out_valid, out_row, out_err,
    output out_idx, out_last, out_nerr
  );

  modport master (
    output in_valid, in_row, cross_prob, out_ready,
    input  in_ready, out_valid, out_row, out_err,
    input  out_idx, out_last, out_nerr
  );

endinterface

// File: rtl/lfsr32_lane.sv
// One channel lane: 32-bit Galois LFSR and a
// threshold compare producing one error bit.
module lfsr32_lane
  import pc_pkg::*;
#(
  parameter int unsigned IDX = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [31:0] i_seed,
  input  logic [15:0] i_prob,
  output logic        o_err
);

  logic [31:0] r_lfsr;

  // load the patched seed in INIT, step once per row
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lfsr <= '0;
    end else if (i_load) begin
      r_lfsr <= seed_fix(i_seed, IDX);
    end else if (i_en) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_err = (r_lfsr[15:0] < i_prob);

endmodule

// File: rtl/bsc_channel_256.sv
// BSC noise channel: XORs each accepted row with a
// per-lane LFSR error pattern, one output register.
module bsc_channel_256 #(
  parameter int N      = pc_pkg::N,
  parameter int LANE_W = pc_pkg::LANE_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N*LANE_W-1:0] i_seed,
  bsc_channel_256_if.slave    i_ch
);

  import pc_pkg::*;

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N+1);

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic             r_valid;
  logic [N-1:0]     r_row;
  logic [N-1:0]     r_err;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;
  logic [CNT_W-1:0] r_nerr;

  logic [N-1:0]     w_err;
  logic [CNT_W-1:0] w_nerr;
  logic             w_acc;
  logic             w_load;

  // pairwise adder tree, N a power of two
  function automatic logic [CNT_W-1:0] popcnt(
    input logic [N-1:0] v
  );
    logic [CNT_W-1:0] s [N];
    for (int i = 0; i < N; i++) s[i] = CNT_W'(v[i]);
    for (int w = N / 2; w > 0; w = w / 2)
      for (int j = 0; j < w; j++)
        s[j] = s[2*j] + s[2*j+1];
    return s[0];
  endfunction

  assign w_load = (r_state == ST_INIT);
  assign i_ch.in_ready = (r_state == ST_RUN) &&
                         (!r_valid || i_ch.out_ready);
  assign w_acc  = i_ch.in_valid && i_ch.in_ready;
  assign w_nerr = popcnt(w_err);

  for (genvar g = 0; g < N; g++) begin : g_lane
    lfsr32_lane #(
      .IDX (g)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_load (w_load),
      .i_en   (w_acc),
      .i_seed (i_seed[g*LANE_W +: 32]),
      .i_prob (i_ch.cross_prob),
      .o_err  (w_err[g])
    );
  end

  // control FSM plus single output register slot
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_row   <= '0;
      r_err   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_nerr  <= '0;
    end else begin
      unique case (r_state)
        ST_INIT: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_acc) begin
            r_valid <= 1'b1;
            r_row   <= i_ch.in_row ^ w_err;
            r_err   <= w_err;
            r_idx   <= r_cnt;
            r_last  <= (r_cnt == IDX_W'(N-1));
            r_nerr  <= w_nerr;
            r_cnt   <= r_cnt + 1'b1;
          end else if (i_ch.out_ready) begin
            r_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign i_ch.out_valid = r_valid;
  assign i_ch.out_row   = r_row;
  assign i_ch.out_err   = r_err;
  assign i_ch.out_idx   = r_idx;
  assign i_ch.out_last  = r_last;
  assign i_ch.out_nerr  = r_nerr;

endmodule

// File: tb/tb_bsc_channel_256.sv
// Scoreboard bench for bsc_channel_256 against a
// lane-array LFSR reference model.
module tb_bsc_channel_256;

  localparam int N = 256;

  typedef struct packed {
    logic [N-1:0] row;
    logic [N-1:0] err;
    logic [7:0]   idx;
    logic         last;
    logic [8:0]   nerr;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*32-1:0] seed;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;
  int phase = 0;
  int err_sum = 0;

  exp_t q[$];
  exp_t held;
  exp_t cur;
  exp_t e;
  bit   stalled = 0;

  logic [31:0] m_lfsr [N];
  int          m_cnt;

  bsc_channel_256_if #(.N(N)) ch();

  bsc_channel_256 #(
    .N     (N),
    .LANE_W(32)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_seed (seed),
    .i_ch   (ch)
  );

  always #5 clk = ~clk;

  // polynomial exponents 32,22,2,1 -> shift-right taps
  function automatic logic [31:0] ref_next(
    input logic [31:0] s
  );
    logic [31:0] taps;
    taps = (32'd1 << 31) | (32'd1 << 21) |
           (32'd1 << 1) | 32'd1;
    return s[0] ? ({1'b0, s[31:1]} ^ taps)
                : {1'b0, s[31:1]};
  endfunction

  task automatic model_load(input logic [N*32-1:0] sd);
    logic [31:0] s;
    for (int i = 0; i < N; i++) begin
      s = sd[32*i +: 32];
      if (s == 0) begin
        s = 32'd1 ^ 32'(i);
        if (s == 0) s = 32'd1;
      end
      m_lfsr[i] = s;
    end
    m_cnt = 0;
  endtask

  task automatic model_push(
    input logic [N-1:0] row,
    input logic [15:0]  p
  );
    exp_t x;
    for (int i = 0; i < N; i++)
      x.err[i] = (m_lfsr[i][15:0] < p);
    x.row  = row ^ x.err;
    x.nerr = 9'($countones(x.err));
    x.idx  = 8'(m_cnt);
    x.last = (m_cnt == N - 1);
    m_cnt  = (m_cnt + 1) % N;
    for (int i = 0; i < N; i++)
      m_lfsr[i] = ref_next(m_lfsr[i]);
    q.push_back(x);
  endtask

  function automatic logic [N-1:0] rnd_row();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++)
      r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(
    input string        nm,
    input logic [N-1:0] act,
    input logic [N-1:0] want
  );
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  // out_ready: 0 = always 1, 1 = random, 2 = held low
  initial begin
    ch.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       ch.out_ready = 1'b1;
        1:       ch.out_ready = 1'($urandom % 2);
        default: ch.out_ready = 1'b0;
      endcase
    end
  end

  // monitor: stall stability and scoreboard pops
  always @(negedge clk) begin
    cur = {ch.out_row, ch.out_err, ch.out_idx,
           ch.out_last, ch.out_nerr};
    if (!rst_n || !ch.out_valid) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        vectors++;
        if (cur !== held) begin
          miscompares++;
          $display("FAIL stall_stable idx got=%0d want=%0d",
                   ch.out_idx, held.idx);
        end
      end
      if (ch.out_ready) begin
        stalled = 0;
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_row idx=%0d queue empty",
                   ch.out_idx);
        end else begin
          e = q.pop_front();
          chk("row",  ch.out_row, e.row);
          chk("err",  ch.out_err, e.err);
          chk("idx",  N'(ch.out_idx), N'(e.idx));
          chk("last", N'(ch.out_last), N'(e.last));
          chk("nerr", N'(ch.out_nerr), N'(e.nerr));
          if (phase == 3) err_sum += int'(ch.out_nerr);
        end
      end else begin
        stalled = 1;
        held = cur;
      end
    end
  end

  task automatic send(
    input logic [N-1:0] row,
    input logic [15:0]  p
  );
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    ch.in_valid   = 1'b1;
    ch.in_row     = row;
    ch.cross_prob = p;
    while (!ok && n < 1000) begin
      @(negedge clk);
      if (ch.in_ready) ok = 1;
      else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    if (ok) begin
      model_push(row, p);
      @(posedge clk);
      #1;
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout in_ready=%0b want=1",
               ch.in_ready);
    end
    ch.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout left=%0d want=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N*32-1:0] sd);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ch.in_valid = 1'b0;
    seed = sd;
    @(posedge clk);
    q.delete();
    repeat (3) begin
      @(negedge clk);
      vectors++;
      chk("rst_valid", N'(ch.out_valid), '0);
      chk("rst_ready", N'(ch.in_ready), '0);
      chk("rst_row",   ch.out_row, '0);
      chk("rst_err",   ch.out_err, '0);
      chk("rst_idx",   N'(ch.out_idx), '0);
      chk("rst_last",  N'(ch.out_last), '0);
      chk("rst_nerr",  N'(ch.out_nerr), '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_load(sd);
    @(negedge clk);
    vectors++;
    chk("init_ready", N'(ch.in_ready), '0);
  endtask

  function automatic logic [N*32-1:0] rnd_seed();
    logic [N*32-1:0] s;
    for (int i = 0; i < N; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  initial begin
    logic [15:0] p;
    ch.in_valid   = 1'b0;
    ch.in_row     = '0;
    ch.cross_prob = '0;
    seed          = rnd_seed();

    do_reset(rnd_seed());

    // no noise: rows pass through, last on 255/511
    rdy_mode = 0;
    for (int i = 0; i < 512; i++) send(rnd_row(), 16'h0000);
    drain();

    // near-certain flips on zero rows
    for (int i = 0; i < 256; i++) send('0, 16'hFFFF);
    drain();

    // p = 1/32 over one frame
    phase   = 3;
    err_sum = 0;
    for (int i = 0; i < 256; i++) send(rnd_row(), 16'h0800);
    drain();
    phase = 0;
    vectors++;
    if (err_sum < 1848 || err_sum > 2248) begin
      miscompares++;
      $display("FAIL err_total got=%0d want=2048+-200",
               err_sum);
    end

    // random backpressure and input gaps
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom % 3) @(posedge clk);
      #1;
      case ($urandom % 3)
        0:       p = 16'h0800;
        1:       p = 16'h4000;
        default: p = 16'($urandom);
      endcase
      send(rnd_row(), p);
    end
    drain();
    rdy_mode = 0;

    // reset at row 100 with a row held in flight
    for (int i = 0; i < 100; i++) send(rnd_row(), 16'hFFFF);
    rdy_mode = 2;
    do_reset(rnd_seed());
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) send(rnd_row(), 16'hFFFF);
    drain();

    // all-zero seeds get replaced per lane
    do_reset('0);
    for (int i = 0; i < 64; i++) send('0, 16'hFFFF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired queue=%0d want=0",
             q.size());
    $fatal(1);
  end

endmodule

// File: doc/bsc_channel_256.md
BSC_CHANNEL_256 -- requirements
Module: bsc_channel_256

Interface
REQ-001 SHALL have parameter N, default 256, meaning codeword row width in bits and rows per frame.
REQ-002 SHALL have parameter LANE_W, default 32, meaning per-lane LFSR width; seed width = N*LANE_W.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 seed  input  8192  lane seeds; lane i uses seed[32*i+31:32*i]; sampled only during reset.
REQ-006 cross_prob  input  16  BSC crossover probability, p = cross_prob/65536; sampled on each accepted row.
REQ-007 in_valid  input  1  upstream encoder row valid.
REQ-008 in_ready  output  1  block can accept a row this cycle.
REQ-009 in_row  input  256  encoded product-code row.
REQ-010 out_valid  output  1  noisy row valid to decoder.
REQ-011 out_ready  input  1  decoder accepts out_row this cycle.
REQ-012 out_row  output  256  in_row XOR error pattern.
REQ-013 out_err  output  256  error pattern applied (1 = flipped bit).
REQ-014 out_idx  output  8  row index within frame, 0..255.
REQ-015 out_last  output  1  high with row index 255.
REQ-016 out_nerr  output  9  popcount of out_err, 0..256.

Function
REQ-017 Each lane i SHALL hold a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
REQ-018 Bit i of the error pattern SHALL be 1 iff lane i LFSR[15:0] < cross_prob (unsigned); cross_prob=0 gives no errors, 65535 gives flip unless LFSR[15:0]=65535.
REQ-019 States: INIT (one cycle after reset release, loads seeds), RUN; INIT->RUN unconditionally; no other transitions except reset.
REQ-020 in_ready SHALL be 0 in INIT; in RUN in_ready = !out_valid || out_ready (single output register, no bubbles under continuous flow).
REQ-021 A row SHALL be accepted when in_valid && in_ready; on accept, out_row/out_err/out_idx/out_last/out_nerr register the result and out_valid=1 next cycle (latency 1).
REQ-022 All lane LFSRs SHALL advance exactly one step per accepted row and hold otherwise; error pattern uses pre-advance LFSR state.
REQ-023 out_valid held high with all outputs stable while out_ready=0; cleared after out_ready=1 with no new accept in the same cycle.
REQ-024 Simultaneous out_ready and accept SHALL replace the output register with the new row, out_valid stays 1.
REQ-025 Row counter SHALL increment per accept and wrap 255->0; out_last=1 iff registered idx=255.
REQ-026 out_nerr SHALL equal popcount(out_err), registered in the same cycle as out_err.
REQ-027 A zero lane seed SHALL be replaced by 32'h0000_0001 XOR i at load to avoid LFSR lock-up.

Reset
REQ-028 While reset=0: out_valid=0, in_ready=0, out_row=0, out_err=0, out_idx=0, out_last=0, out_nerr=0, state=INIT, row counter=0.
REQ-029 LFSRs SHALL load from seed in INIT (the cycle after reset=1 first seen); reset mid-frame discards the in-flight row and restarts at idx 0 with fresh seeds.

Structure
REQ-030 Shared package pc_pkg SHALL hold N, LANE_W, LFSR polynomial constant, state enum, and the zero-seed replacement constant.
REQ-031 One sub-module lfsr32_lane (seed load, enable, 32-bit state, 16-bit compare to cross_prob, error bit out) SHALL be instantiated N times via generate.
REQ-032 Popcount SHALL be an adder tree inside bsc_channel_256; no multi-cycle logic.

Verification
REQ-033 cross_prob=0, random rows, out_ready=1: out_row==in_row, out_err=0, out_nerr=0 for 512 rows; out_last on rows 255 and 511.
REQ-034 cross_prob=65535, in_row=0: out_row==out_err, out_nerr matches count of lanes with LFSR[15:0]!=65535 from a reference model, bit-exact for 256 rows.
REQ-035 cross_prob=16'h0800 (p=1/32), 256 rows: out_err bit-exact to C/Python LFSR model; total errors within 2048±200.
REQ-036 out_ready toggled randomly 50%: outputs stable while stalled, no row lost/duplicated, LFSR sequence identical to unstalled run.
REQ-037 Reset asserted at row 100 then released: out_valid=0 during reset, first post-reset row idx=0 and err pattern equals first row of a fresh run.
REQ-038 All-zero seed: every lane produces nonzero LFSR sequence per REQ-027; no lane stuck at all-zero error pattern at cross_prob=65535.
